// File: rtl/ram_fifo_ctrl_if.sv
// ram_fifo_ctrl_if
//   Push/pop handshake bundle between a datapath and ram_fifo_ctrl.
//   Optional macro: RAM_FIFO_FLAGS_EN adds almost_full / almost_empty.
//   Signals:
//     push_valid, push_data  : datapath -> controller, enqueue request
//     push_ready             : controller -> datapath, push taken this edge
//     pop_req                : datapath -> controller, dequeue request
//     pop_valid, pop_data    : controller -> datapath, one-cycle result pulse
//     empty, full, count     : controller -> datapath, occupancy status
//   Modports: master (datapath side), slave (controller side).
interface ram_fifo_ctrl_if #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned ADDR_W = 4
);
    logic              push_valid;
    logic [DATA_W-1:0] push_data;
    logic              push_ready;
    logic              pop_req;
    logic              pop_valid;
    logic [DATA_W-1:0] pop_data;
    logic              empty;
    logic              full;
    logic [ADDR_W:0]   count;
`ifdef RAM_FIFO_FLAGS_EN
    logic              almost_full;
    logic              almost_empty;
`endif

    modport master (
        output push_valid, push_data, pop_req,
`ifdef RAM_FIFO_FLAGS_EN
        input  almost_full, almost_empty,
`endif
        input  push_ready, pop_valid, pop_data, empty, full, count
    );

    modport slave (
        input  push_valid, push_data, pop_req,
`ifdef RAM_FIFO_FLAGS_EN
        output almost_full, almost_empty,
`endif
        output push_ready, pop_valid, pop_data, empty, full, count
    );
endinterface

// File: rtl/ram_fifo_ctrl.sv
// ram_fifo_ctrl
//   FIFO controller in front of a single-port RAM (we/enable/addr/bidir data).
//   Every access is serialised through an IDLE/WRITE/READ state machine, so
//   the RAM sees at most one access per state and never read+write together.
//   Pointers and occupancy live here; the RAM only holds the words.
//   Optional macro: RAM_FIFO_FLAGS_EN adds registered almost_full/almost_empty
//   and the AF_THRESH/AE_THRESH parameters.
//   Ports:
//     clock, resetn  : clock, asynchronous active-low reset
//     fifo           : push/pop handshake and status (slave modport)
//     ram_we         : RAM write strobe (WRITE state only)
//     ram_enable     : RAM read enable (READ state only)
//     ram_addr       : RAM address
//     ram_data       : RAM bus, driven only while writing, high-Z otherwise
module ram_fifo_ctrl #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned ADDR_W = 4
`ifdef RAM_FIFO_FLAGS_EN
    ,
    parameter int unsigned AF_THRESH = 14,
    parameter int unsigned AE_THRESH = 2
`endif
) (
    input  logic              clock,
    input  logic              resetn,
    ram_fifo_ctrl_if.slave    fifo,
    output logic              ram_we,
    output logic              ram_enable,
    output logic [ADDR_W-1:0] ram_addr,
    inout  logic [DATA_W-1:0] ram_data
);
    localparam logic [ADDR_W:0] DEPTH = (ADDR_W+1)'(1 << ADDR_W);
`ifdef RAM_FIFO_FLAGS_EN
    localparam logic [ADDR_W:0] AF_LVL = (ADDR_W+1)'(AF_THRESH);
    localparam logic [ADDR_W:0] AE_LVL = (ADDR_W+1)'(AE_THRESH);
`endif

    typedef enum logic [1:0] {IDLE, WRITE, READ} state_t;

    state_t            state;
    logic [ADDR_W-1:0] wr_ptr;
    logic [ADDR_W-1:0] rd_ptr;
    logic [ADDR_W:0]   count_q;
    logic [DATA_W-1:0] wdata_q;
    logic [DATA_W-1:0] pop_data_q;
    logic              pop_valid_q;
    logic              empty_w;
    logic              full_w;
`ifdef RAM_FIFO_FLAGS_EN
    logic              almost_full_q;
    logic              almost_empty_q;
`endif

    // Status comes from the occupancy count, not pointer comparison.
    assign empty_w = (count_q == '0);
    assign full_w  = (count_q == DEPTH);

    assign fifo.empty      = empty_w;
    assign fifo.full       = full_w;
    assign fifo.count      = count_q;
    assign fifo.pop_valid  = pop_valid_q;
    assign fifo.pop_data   = pop_data_q;
    // A pending pop wins the IDLE slot, so a push offered alongside it waits.
    assign fifo.push_ready = (state == IDLE) && !full_w && !(fifo.pop_req && !empty_w);
`ifdef RAM_FIFO_FLAGS_EN
    assign fifo.almost_full  = almost_full_q;
    assign fifo.almost_empty = almost_empty_q;
`endif

    // ram_we is high only in WRITE, which is also the only time we drive the bus.
    assign ram_data = ram_we ? wdata_q : 'z;

    // ram_we/ram_enable are registered on entry to WRITE/READ and cleared on
    // exit, which makes them equal to a decode of the state register.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state          <= IDLE;
            wr_ptr         <= '0;
            rd_ptr         <= '0;
            count_q        <= '0;
            wdata_q        <= '0;
            pop_data_q     <= '0;
            pop_valid_q    <= 1'b0;
            ram_we         <= 1'b0;
            ram_enable     <= 1'b0;
            ram_addr       <= '0;
`ifdef RAM_FIFO_FLAGS_EN
            almost_full_q  <= 1'b0;
            almost_empty_q <= 1'b1;
`endif
        end else begin
            pop_valid_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (fifo.pop_req && !empty_w) begin
                        state      <= READ;
                        ram_enable <= 1'b1;
                        ram_addr   <= rd_ptr;
                    end else if (fifo.push_valid && !full_w) begin
                        state    <= WRITE;
                        ram_we   <= 1'b1;
                        ram_addr <= wr_ptr;
                        wdata_q  <= fifo.push_data;
                    end
                end
                WRITE: begin
                    state   <= IDLE;
                    ram_we  <= 1'b0;
                    wr_ptr  <= wr_ptr + 1'b1;
                    count_q <= count_q + 1'b1;
`ifdef RAM_FIFO_FLAGS_EN
                    almost_full_q  <= (count_q + 1'b1) >= AF_LVL;
                    almost_empty_q <= (count_q + 1'b1) <= AE_LVL;
`endif
                end
                READ: begin
                    state       <= IDLE;
                    ram_enable  <= 1'b0;
                    pop_data_q  <= ram_data;
                    pop_valid_q <= 1'b1;
                    rd_ptr      <= rd_ptr + 1'b1;
                    count_q     <= count_q - 1'b1;
`ifdef RAM_FIFO_FLAGS_EN
                    almost_full_q  <= (count_q - 1'b1) >= AF_LVL;
                    almost_empty_q <= (count_q - 1'b1) <= AE_LVL;
`endif
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_ram_fifo_ctrl.sv
`timescale 1ns/1ps
module tb_ram_fifo_ctrl;
    localparam int DW    = 8;
    localparam int AW    = 4;
    localparam int DEPTH = 16;

    logic          clock = 1'b0;
    logic          resetn = 1'b0;
    logic          ram_we;
    logic          ram_enable;
    logic [AW-1:0] ram_addr;
    wire  [DW-1:0] ram_data;
    logic [DW-1:0] mem [DEPTH];

    ram_fifo_ctrl_if #(.DATA_W(DW), .ADDR_W(AW)) fifo ();

    ram_fifo_ctrl #(.DATA_W(DW), .ADDR_W(AW)) dut (
        .clock      (clock),
        .resetn     (resetn),
        .fifo       (fifo),
        .ram_we     (ram_we),
        .ram_enable (ram_enable),
        .ram_addr   (ram_addr),
        .ram_data   (ram_data)
    );

    always #5 clock = ~clock;

    // Behavioural 16x8 single-port RAM: async read onto the bus when enabled.
    assign ram_data = ram_enable ? mem[ram_addr] : 'z;
    always @(posedge clock) if (ram_we) mem[ram_addr] <= ram_data;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    typedef struct {
        int cyc;
        int addr;
        int data;
    } ev_t;

    ev_t          wq[$];     // expected RAM writes
    ev_t          rq[$];     // expected RAM reads
    ev_t          pq[$];     // expected pop_valid results
    logic [DW-1:0] model[$]; // reference FIFO contents
    int           waddr_m = 0;
    int           raddr_m = 0;
    int           n_cmp = 0;
    int           n_bad = 0;
    ev_t          me;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic unexpected(input string name);
        n_cmp++;
        n_bad++;
        $display("FAIL %s: got 1 expected 0 (no event queued, cycle %0d)", name, cyc);
    endtask

    // Monitor: pops expectations whenever the DUT presents a RAM access or result.
    always @(negedge clock) begin
        if (resetn) begin
            if (ram_we && ram_enable) unexpected("we_and_enable");
            if (ram_we) begin
                if (wq.size() == 0) unexpected("ram_we");
                else begin
                    me = wq.pop_front();
                    chk("write_cycle", cyc, me.cyc);
                    chk("write_addr", ram_addr, me.addr);
                    chk("write_data", ram_data, me.data);
                end
            end
            if (ram_enable) begin
                if (rq.size() == 0) unexpected("ram_enable");
                else begin
                    me = rq.pop_front();
                    chk("read_cycle", cyc, me.cyc);
                    chk("read_addr", ram_addr, me.addr);
                end
            end
            if (fifo.pop_valid) begin
                if (pq.size() == 0) unexpected("pop_valid");
                else begin
                    me = pq.pop_front();
                    chk("pop_cycle", cyc, me.cyc);
                    chk("pop_data", fifo.pop_data, me.data);
                end
            end
        end
    end

    // Called with push_valid/pop_req low and the controller idle.
    task automatic status(input string tag);
        chk({tag, ".count"}, fifo.count, model.size());
        chk({tag, ".empty"}, fifo.empty, model.size() == 0);
        chk({tag, ".full"}, fifo.full, model.size() == DEPTH);
        chk({tag, ".push_ready"}, fifo.push_ready, model.size() < DEPTH);
`ifdef RAM_FIFO_FLAGS_EN
        chk({tag, ".almost_full"}, fifo.almost_full, model.size() >= 14);
        chk({tag, ".almost_empty"}, fifo.almost_empty, model.size() <= 2);
`endif
    endtask

    task automatic do_push(input logic [DW-1:0] d);
        fifo.push_valid = 1'b1;
        fifo.push_data  = d;
        fifo.pop_req    = 1'b0;
        #1;
        chk("push_ready_offer", fifo.push_ready, model.size() < DEPTH);
        if (model.size() < DEPTH) begin
            wq.push_back('{cyc + 1, waddr_m, d});
            model.push_back(d);
            waddr_m = (waddr_m + 1) % DEPTH;
        end
        @(posedge clock);
        #1 fifo.push_valid = 1'b0;
        @(negedge clock);
        @(negedge clock);
        status("push");
    endtask

    task automatic do_pop();
        fifo.pop_req = 1'b1;
        #1;
        if (model.size() > 0) begin
            rq.push_back('{cyc + 1, raddr_m, 0});
            pq.push_back('{cyc + 2, 0, model.pop_front()});
            raddr_m = (raddr_m + 1) % DEPTH;
        end
        @(posedge clock);
        #1 fifo.pop_req = 1'b0;
        @(negedge clock);
        @(negedge clock);
        status("pop");
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [DW-1:0] d;
        fifo.push_valid = 1'b0;
        fifo.push_data  = '0;
        fifo.pop_req    = 1'b0;
        resetn = 1'b0;
        repeat (3) @(negedge clock);
        resetn = 1'b1;
        #1;
        status("reset");
        chk("reset.ram_we", ram_we, 0);
        chk("reset.ram_enable", ram_enable, 0);
        chk("reset.pop_valid", fifo.pop_valid, 0);
        chk("reset.pop_data", fifo.pop_data, 0);
        @(negedge clock);

        // Fill completely, then one push too many.
        for (int i = 0; i < DEPTH; i++) do_push(8'hA0 + 8'(i));
        chk("fill.count", fifo.count, 16);
        chk("fill.full", fifo.full, 1);
        do_push(8'h55);

        // Drain completely, then one pop too many.
        for (int i = 0; i < DEPTH + 1; i++) do_pop();
        chk("drain.empty", fifo.empty, 1);

        // Pointer wrap-around.
        for (int i = 0; i < 10; i++) do_push(8'($urandom));
        for (int i = 0; i < 10; i++) do_pop();
        for (int i = 0; i < 10; i++) do_push(8'($urandom));
        chk("wrap.count", fifo.count, 10);
        for (int i = 0; i < 7; i++) do_pop();

        // Simultaneous push and pop with three entries: pop goes first.
        d = 8'($urandom);
        fifo.push_valid = 1'b1;
        fifo.push_data  = d;
        fifo.pop_req    = 1'b1;
        #1;
        chk("simul.count0", fifo.count, 3);
        chk("simul.push_ready_idle", fifo.push_ready, 0);
        rq.push_back('{cyc + 1, raddr_m, 0});
        pq.push_back('{cyc + 2, 0, model.pop_front()});
        raddr_m = (raddr_m + 1) % DEPTH;
        @(posedge clock);
        #1 fifo.pop_req = 1'b0;
        @(negedge clock);
        chk("simul.push_ready_read", fifo.push_ready, 0);
        @(negedge clock);
        chk("simul.count1", fifo.count, 2);
        chk("simul.push_ready_after", fifo.push_ready, 1);
        wq.push_back('{cyc + 1, waddr_m, d});
        model.push_back(d);
        waddr_m = (waddr_m + 1) % DEPTH;
        @(posedge clock);
        #1 fifo.push_valid = 1'b0;
        @(negedge clock);
        @(negedge clock);
        chk("simul.count2", fifo.count, 3);

        // Randomised mix of pushes, pops and idle gaps.
        for (int i = 0; i < 300; i++) begin
            int r;
            r = $urandom_range(0, 9);
            if (r < 5) do_push(8'($urandom));
            else if (r < 9) do_pop();
            else begin
                repeat ($urandom_range(1, 3)) @(negedge clock);
                status("idle");
            end
        end
        while (model.size() > 0) do_pop();

        // Reset asserted in the middle of a WRITE cycle.
        fifo.push_valid = 1'b1;
        fifo.push_data  = 8'h3C;
        #1;
        chk("rst.push_ready", fifo.push_ready, 1);
        @(posedge clock);
        #1 fifo.push_valid = 1'b0;
        chk("rst.ram_we_before", ram_we, 1);
        #2 resetn = 1'b0;
        #1;
        wq.delete();
        rq.delete();
        pq.delete();
        model.delete();
        waddr_m = 0;
        raddr_m = 0;
        chk("rst.ram_we_after", ram_we, 0);
        chk("rst.ram_enable", ram_enable, 0);
        status("rst");
        @(negedge clock);
        @(negedge clock);
        resetn = 1'b1;
        #1;
        do_push(8'h11);
        do_push(8'h22);
        do_pop();
        do_pop();

        repeat (4) @(negedge clock);
        chk("end.writes_left", wq.size(), 0);
        chk("end.reads_left", rq.size(), 0);
        chk("end.pops_left", pq.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/ram_fifo_ctrl.md
Name: ram_fifo_ctrl

Overview:
- Synchronous FIFO controller that sits directly upstream of the 16x8 single-port RAM (ports we, enable, addr, bidirectional data).
- Presents a push/pop FIFO interface to the datapath.
- Serialises all accesses onto the single RAM port: one access per state, never a read and a write together.
- Owns the read/write pointers and the occupancy count; the RAM holds the storage.

Parameters:
- DATA_W, 8, data word width (matches RAM data bus).
- ADDR_W, 4, RAM address width; FIFO depth = 2**ADDR_W = 16.
- AF_THRESH, 14, almost_full asserts when count >= AF_THRESH (optional feature only).
- AE_THRESH, 2, almost_empty asserts when count <= AE_THRESH (optional feature only).

Ports:
- clock  input  1  single clock; all state changes on the rising edge.
- resetn  input  1  asynchronous, active-low reset.
- push_valid  input  1  write request; push_data is valid.
- push_data  input  DATA_W  word to enqueue.
- push_ready  output  1  push is accepted on a clock edge where push_valid && push_ready.
- pop_req  input  1  read request.
- pop_valid  output  1  one-cycle pulse; pop_data holds the dequeued word.
- pop_data  output  DATA_W  registered dequeued word; held until the next pop.
- empty  output  1  count == 0.
- full  output  1  count == 2**ADDR_W.
- count  output  ADDR_W+1  occupancy, 0..16.
- ram_we  output  1  RAM write strobe.
- ram_enable  output  1  RAM read enable.
- ram_addr  output  ADDR_W  RAM address.
- ram_data  inout  DATA_W  RAM bus; driven only in WRITE, high-Z otherwise.

Behaviour:
- Reset (asynchronous, takes effect immediately, including mid-operation):
  - state = IDLE; wr_ptr = rd_ptr = 0; count = 0.
  - pop_valid = 0; pop_data = 0; ram_we = 0; ram_enable = 0; ram_addr = 0; ram_data = Z.
  - RAM contents are not cleared.
- FSM has three states: IDLE, WRITE, READ. RAM controls are decoded from state (Moore outputs).
- IDLE:
  - ram_we = 0, ram_enable = 0, bus Z.
  - If pop_req && !empty → READ; rd_ptr is latched into ram_addr.
  - Else if push_valid && !full → WRITE; push_data is captured into wdata_q and wr_ptr into ram_addr.
  - Else stay in IDLE.
  - push_ready = (state==IDLE) && !full && !(pop_req && !empty). Pop has priority; a push offered in the same cycle waits.
- WRITE (exactly 1 cycle):
  - ram_we = 1, ram_enable = 0, ram_addr = wr_ptr, ram_data = wdata_q.
  - At exit: wr_ptr += 1 (mod 16), count += 1, → IDLE.
- READ (exactly 1 cycle):
  - ram_we = 0, ram_enable = 1, ram_addr = rd_ptr, bus Z (the RAM drives it).
  - At exit: pop_data <= ram_data, rd_ptr += 1 (mod 16), count -= 1, → IDLE.
  - pop_valid = 1 for the following single cycle.
- Latency and throughput:
  - Push: accepted at edge N, RAM write during cycle N+1.
  - Pop: requested at edge N, pop_valid in cycle N+2.
  - Maximum throughput is one access per 2 cycles.
- Boundary conditions:
  - Pointers wrap 15 → 0 naturally.
  - full and empty are derived from count, never from pointer equality.
  - Pop while empty: ignored, no RAM access, pop_valid stays 0.
  - Push while full: push_ready = 0, data not taken.
  - ram_we and ram_enable are never both 1.
  - The controller never drives ram_data while ram_enable = 1.

Optional Feature:
- Macro: RAM_FIFO_FLAGS_EN.
- Defined:
  - Adds output ports almost_full (count >= AF_THRESH) and almost_empty (count <= AE_THRESH), both registered alongside count.
  - Reset values: almost_full = 0, almost_empty = 1.
- Undefined: these ports and their logic do not exist; all other behaviour is identical.

Test Plan:
- Reset then idle → count=0, empty=1, full=0, push_ready=1, ram_we=0, ram_enable=0, ram_data=Z.
- Push 0xA0..0xAF back-to-back → RAM writes to addresses 0..15 with matching data; after 16th push full=1, count=16, push_ready=0; 17th push ignored.
- Pop 16 times → pop_data sequence 0xA0..0xAF, each with a one-cycle pop_valid two cycles after the request; ends with empty=1; extra pop gives no ram_enable pulse.
- Wrap-around: push 10, pop 10, push 10 → second batch written to addresses 10..15 then 0..3; popped in order; count returns to 10.
- Simultaneous push_valid and pop_req with count=3 → READ first, push_ready=0 that cycle; push completes on a later IDLE; count goes 3 → 2 → 3.
- Assert resetn low during WRITE → ram_we falls without waiting for clock, bus goes Z, count=0; with RAM_FIFO_FLAGS_EN, almost_empty=1.
